fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
- Pipelined IEEE-754 single-precision multiplier for the CNN datapath.
- Sits directly upstream of the float adder. It turns weight×activation pairs into products that the accumulation stage sums.
- Uses the same numeric simplifications as the adder: no denormals, truncation rounding, flush-to-zero.
- Three-stage pipeline with valid/ready handshake, plus a sideband tag and last-flag passthrough.

Parameters:
- TAG_W, 4, width of the sideband tag (e.g. output-channel index) carried alongside each product.

Ports:
- MAIN_CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  stage accepts operands this cycle.
- in_a  in  32  float32 operand (activation).
- in_b  in  32  float32 operand (weight).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- in_last  in  1  marks final product of a window, passed through.
- out_valid  out  1  product present.
- out_ready  in  1  downstream accepts product.
- out_data  out  32  float32 product.
- out_tag  out  TAG_W  tag aligned with out_data.
- out_last  out  1  last flag aligned with out_data.

Behaviour:
- Reset (RST_N low, asynchronous):
  - All stage valid bits, out_valid, out_data, out_tag and out_last go to 0.
  - In-flight operands are discarded.
  - in_ready is 1 from the first cycle after release.
- Advance enable: en = !out_valid || out_ready.
  - in_ready = en.
  - The whole pipeline shifts only when en=1.
  - When en=0, every stage holds data and valid. No loss, no duplication.
- Transfer rule: input transfers when in_valid && in_ready; output transfers when out_valid && out_ready.
- Latency: 3 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Bubbles (in_valid=0 with en=1) propagate as invalid stages. Each stage carries its own valid bit.
- S1 (unpack):
  - sign = a[31]^b[31].
  - Exponent sum e = ea + eb − 127, computed as 10-bit signed.
  - Mantissas become {1,frac}, 24 bits each.
  - zero_flag = (ea==0) || (eb==0).
- S2 (multiply): 48-bit product p = ma × mb, registered. sign, e, zero_flag, tag and last are piped alongside.
- S3 (normalise/pack):
  - If p[47]=1: frac = p[46:24], e = e+1. Otherwise frac = p[45:23].
  - Rounding is truncation; no rounding increment.
  - zero_flag=1 or e ≤ 0 → out_data = 32'h0 (positive zero).
  - e ≥ 255 → saturate to {sign, 8'hFE, 23'h7FFFFF}.
  - Otherwise out_data = {sign, e[7:0], frac}.
- Exponent 255 inputs (Inf/NaN) are treated as ordinary numbers and saturate by the rule above. This is not IEEE-compliant, by design.
- Holding out_valid=1 with out_ready=0: out_data, out_tag and out_last stay stable until accepted.
- Simultaneous accept and new input while full: allowed, because en=1 when out_ready=1.

Decomposition:
- Shared package fp_pkg:
  - Constants FP_BIAS=127, FP_EXP_MAX=8'hFE, FP_FRAC_MAX=23'h7FFFFF, FP_ZERO=32'h0.
  - Field widths EXP_W=8, FRAC_W=23.
  - These are shared with the adder stage and the accumulator.
- One sub-module: fp_mul_norm, the combinational S3 normalise/saturate/pack logic. It is reused by any future fused stage.

Test Plan:
- 0x40000000 × 0x40400000 (2.0×3.0), out_ready=1 → out_data 0x40C00000 exactly 3 cycles after input transfer.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5) → 0x40100000, exercising the p[47] normalise path. Also 0xC0000000 × 0x3F000000 → 0xBF800000 (sign).
- 0x00000000 × 0x40490FDB → 0x00000000; 0x00800000 × 0x00800000 (underflow) → 0x00000000.
- 0x7F000000 × 0x7F000000 (overflow) → 0x7F7FFFFF.
- Back-to-back stream of 8 pairs with tags 0..7, in_last on the 8th, then out_ready low for 5 cycles mid-stream:
  - in_ready drops within the same cycle.
  - All 8 products emerge in order with matching tags, and last set only on tag 7.
  - out_data is stable while stalled.
- Assert RST_N low with 3 operations in flight → out_valid 0 immediately. After release, the next input yields a correct result with no stale output.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared float32 constants, field widths and stage record types
//             for the CNN float datapath (multiplier, adder, accumulator).
//  Contents : FP_BIAS, FP_EXP_MAX, FP_FRAC_MAX, FP_ZERO, EXP_W, FRAC_W,
//             exp_sum_t, multiplier stage records, exp_sum() helper.
//  Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;      // mantissa with hidden one
    localparam int PROD_W = 2 * MANT_W;      // full mantissa product
    localparam int ESUM_W = 10;              // signed exponent-sum width

    localparam int                 FP_BIAS     = 127;
    localparam logic [EXP_W-1:0]   FP_EXP_MAX  = 8'hFE;
    localparam logic [FRAC_W-1:0]  FP_FRAC_MAX = 23'h7FFFFF;
    localparam logic [31:0]        FP_ZERO     = 32'h0;

    // Signed so that underflowed exponent sums compare naturally against 0.
    typedef logic signed [ESUM_W-1:0] exp_sum_t;

    // Unpacked operand pair (stage 1 contents).
    typedef struct packed {
        logic              sign;
        exp_sum_t          exp;
        logic              zero;
        logic [MANT_W-1:0] ma;
        logic [MANT_W-1:0] mb;
    } mul_s1_t;

    // Raw product with its side information (stage 2 contents).
    typedef struct packed {
        logic              sign;
        exp_sum_t          exp;
        logic              zero;
        logic [PROD_W-1:0] prod;
    } mul_s2_t;

    // Biased exponent of a product before normalisation: ea + eb - bias.
    function automatic exp_sum_t exp_sum(input logic [EXP_W-1:0] ea,
                                         input logic [EXP_W-1:0] eb);
        return exp_sum_t'({2'b00, ea}) + exp_sum_t'({2'b00, eb})
               - exp_sum_t'(FP_BIAS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_norm.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_norm
//  Purpose  : Combinational normalise / saturate / pack of a raw float32
//             mantissa product. Truncation rounding, flush-to-zero.
//  Ports    : sign    in   product sign
//             exp_in  in   signed exponent sum (ea + eb - bias)
//             zero    in   either operand had a zero exponent
//             prod    in   48-bit product of {1,frac} mantissas
//             data    out  packed float32 result
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_norm
    import fp_pkg::*;
(
    input  logic              sign,
    input  exp_sum_t          exp_in,
    input  logic              zero,
    input  logic [PROD_W-1:0] prod,
    output logic [31:0]       data
);

    exp_sum_t          w_exp;
    logic [FRAC_W-1:0] w_frac;

    always_comb begin
        w_exp  = exp_in;
        w_frac = prod[PROD_W-3 -: FRAC_W];
        // Product of two [1,2) mantissas lies in [1,4); top bit set means
        // the value is >= 2, so shift right one place and bump the exponent.
        if (prod[PROD_W-1]) begin
            w_exp  = exp_in + exp_sum_t'(1);
            w_frac = prod[PROD_W-2 -: FRAC_W];
        end

        data = FP_ZERO;
        if (zero || (w_exp <= exp_sum_t'(0))) begin
            data = FP_ZERO;
        end else if (w_exp >= exp_sum_t'(255)) begin
            // Largest finite magnitude; Inf/NaN inputs also land here.
            data = {sign, FP_EXP_MAX, FP_FRAC_MAX};
        end else begin
            data = {sign, w_exp[EXP_W-1:0], w_frac};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_pipe
//  Purpose  : Three-stage pipelined float32 multiplier (unpack, multiply,
//             normalise/pack) with valid/ready handshake and tag/last
//             sideband passthrough.
//  Ports    : MAIN_CLK   in   clock, rising edge
//             RST_N      in   asynchronous active-low reset
//             in_valid   in   operand pair present
//             in_ready   out  operands accepted this cycle
//             in_a/in_b  in   float32 operands
//             in_tag     in   sideband tag
//             in_last    in   last-of-window flag
//             out_valid  out  product present
//             out_ready  in   downstream accepts product
//             out_data   out  float32 product
//             out_tag    out  tag aligned with out_data
//             out_last   out  last flag aligned with out_data
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             MAIN_CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last
);

    // The whole pipe moves as one: it advances whenever the output register
    // is empty or being drained, otherwise every stage holds.
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ---------------- stage 1 : unpack ----------------
    mul_s1_t w_s1_next;

    always_comb begin
        w_s1_next.sign = in_a[31] ^ in_b[31];
        w_s1_next.exp  = exp_sum(in_a[30:23], in_b[30:23]);
        w_s1_next.zero = (in_a[30:23] == '0) || (in_b[30:23] == '0);
        w_s1_next.ma   = {1'b1, in_a[22:0]};
        w_s1_next.mb   = {1'b1, in_b[22:0]};
    end

    mul_s1_t          r_s1;
    logic             r_s1_valid;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_last;

    // ---------------- stage 2 : multiply ----------------
    logic [PROD_W-1:0] w_prod;
    assign w_prod = PROD_W'(r_s1.ma) * PROD_W'(r_s1.mb);

    mul_s2_t          r_s2;
    logic             r_s2_valid;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_last;

    // ---------------- stage 3 : normalise / pack ----------------
    logic [31:0] w_norm_data;

    fp_mul_norm u_norm (
        .sign   (r_s2.sign),
        .exp_in (r_s2.exp),
        .zero   (r_s2.zero),
        .prod   (r_s2.prod),
        .data   (w_norm_data)
    );

    always_ff @(posedge MAIN_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_last  <= 1'b0;
            r_s2       <= '0;
            r_s2_valid <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            out_last   <= 1'b0;
        end else if (w_en) begin
            // Stage 1: a bubble (in_valid=0) simply enters as an invalid slot.
            r_s1       <= w_s1_next;
            r_s1_valid <= in_valid;
            r_s1_tag   <= in_tag;
            r_s1_last  <= in_last;

            // Stage 2
            r_s2.sign  <= r_s1.sign;
            r_s2.exp   <= r_s1.exp;
            r_s2.zero  <= r_s1.zero;
            r_s2.prod  <= w_prod;
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
            r_s2_last  <= r_s1_last;

            // Stage 3 / output register
            out_valid  <= r_s2_valid;
            out_data   <= w_norm_data;
            out_tag    <= r_s2_tag;
            out_last   <= r_s2_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_pipe
//  Purpose  : Self-checking bench for fp_mul_pipe: directed vectors, a
//             stalled tagged stream, mid-flight reset and randomized
//             traffic against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_mul_pipe;

    localparam int TAG_W = 4;

    logic             MAIN_CLK = 1'b0;
    logic             RST_N;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_last;

    always #5 MAIN_CLK = ~MAIN_CLK;

    fp_mul_pipe #(.TAG_W(TAG_W)) dut (
        .MAIN_CLK  (MAIN_CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_last  (out_last)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             last;
    } exp_t;

    exp_t sb[$];

    // Downstream ready: either random back-pressure or a held level.
    bit rand_ready = 1'b0;
    bit ready_hold = 1'b1;

    always @(posedge MAIN_CLK) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: real-number float multiply with truncation, flush-to-zero
    // and saturation, done in plain integer arithmetic.
    function automatic logic [31:0] model_mul(input logic [31:0] a,
                                              input logic [31:0] b);
        int              ea, eb, e;
        logic            s;
        longint unsigned ma, mb, p;
        logic [22:0]     f;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (ea == 0 || eb == 0) return 32'h0;
        ma = 64'h80_0000 + longint'(a[22:0]);
        mb = 64'h80_0000 + longint'(b[22:0]);
        p  = ma * mb;                       // value = p * 2^-46 * 2^(ea+eb-254)
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            e = e + 1;
            f = 23'(p >> 24);
        end else begin
            f = 23'(p >> 23);
        end
        if (e <= 0)   return 32'h0;
        if (e >= 255) return {s, 8'hFE, 23'h7FFFFF};
        return {s, 8'(e), f};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        f = 23'($urandom);
        s = 1'($urandom);
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       e = 8'd0;
            2, 3:    e = 8'($urandom_range(100, 154));
            4:       e = 8'($urandom_range(190, 255));
            default: e = 8'($urandom_range(1, 64));
        endcase
        return {s, e, f};
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input logic l);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        in_last  = l;
        n = 0;
        forever begin
            @(negedge MAIN_CLK);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                check("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge MAIN_CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge MAIN_CLK);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge MAIN_CLK);
        #1;
    endtask

    // ---------------- compare process ----------------
    logic             stall_prev = 1'b0;
    logic [31:0]      held_d;
    logic [TAG_W-1:0] held_t;
    logic             held_l;

    initial begin
        exp_t e;
        forever begin
            @(negedge MAIN_CLK);
            if (!RST_N) begin
                stall_prev = 1'b0;
            end else begin
                check("in_ready_en", 32'(in_ready), 32'(!out_valid || out_ready));
                if (stall_prev) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", out_data, held_d);
                    check("stall_tag", 32'(out_tag), 32'(held_t));
                    check("stall_last", 32'(out_last), 32'(held_l));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", out_data, 32'hxxxx_xxxx);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_tag", 32'(out_tag), 32'(e.tag));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                end
                if (in_valid && in_ready) begin
                    e.data = model_mul(in_a, in_b);
                    e.tag  = in_tag;
                    e.last = in_last;
                    sb.push_back(e);
                end
                stall_prev = out_valid && !out_ready;
                held_d     = out_data;
                held_t     = out_tag;
                held_l     = out_last;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        RST_N     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Hand-computed anchors for the model.
        check("pin_2x3",       model_mul(32'h40000000, 32'h40400000), 32'h40C00000);
        check("pin_1p5sq",     model_mul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
        check("pin_sign",      model_mul(32'hC0000000, 32'h3F000000), 32'hBF800000);
        check("pin_zero",      model_mul(32'h00000000, 32'h40490FDB), 32'h00000000);
        check("pin_underflow", model_mul(32'h00800000, 32'h00800000), 32'h00000000);
        check("pin_overflow",  model_mul(32'h7F000000, 32'h7F000000), 32'h7F7FFFFF);

        // Reset state
        repeat (2) @(negedge MAIN_CLK);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'h0);
        check("rst_out_tag",   32'(out_tag), 32'd0);
        check("rst_out_last",  32'(out_last), 32'd0);
        @(posedge MAIN_CLK);
        #1;
        RST_N = 1'b1;
        @(negedge MAIN_CLK);
        check("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge MAIN_CLK);
        #1;

        // Latency: result appears after the third edge counting the transfer edge.
        send(32'h40000000, 32'h40400000, 4'd1, 1'b0);
        @(negedge MAIN_CLK);
        check("lat_e1_valid", 32'(out_valid), 32'd0);
        @(negedge MAIN_CLK);
        check("lat_e2_valid", 32'(out_valid), 32'd0);
        @(negedge MAIN_CLK);
        check("lat_e3_valid", 32'(out_valid), 32'd1);
        check("lat_e3_data",  out_data, 32'h40C00000);
        @(posedge MAIN_CLK);
        #1;
        drain();

        // Remaining directed vectors back-to-back
        send(32'h3FC00000, 32'h3FC00000, 4'd2, 1'b0);
        send(32'hC0000000, 32'h3F000000, 4'd3, 1'b0);
        send(32'h00000000, 32'h40490FDB, 4'd4, 1'b0);
        send(32'h00800000, 32'h00800000, 4'd5, 1'b0);
        send(32'h7F000000, 32'h7F000000, 4'd6, 1'b1);
        drain();

        // Tagged stream of 8 with a 5-cycle downstream stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(rnd_fp(), rnd_fp(), TAG_W'(i), i == 7);
            end
            begin
                repeat (4) @(negedge MAIN_CLK);
                ready_hold = 1'b0;
                repeat (5) @(negedge MAIN_CLK);
                ready_hold = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight
        @(negedge MAIN_CLK);
        ready_hold = 1'b0;
        @(posedge MAIN_CLK);
        #1;
        send(32'h40000000, 32'h40000000, 4'd8, 1'b0);
        send(32'h40400000, 32'h40400000, 4'd9, 1'b0);
        send(32'h40800000, 32'h40800000, 4'd10, 1'b1);
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  out_data, 32'h0);
        sb.delete();
        ready_hold = 1'b1;
        repeat (2) @(posedge MAIN_CLK);
        #1;
        RST_N = 1'b1;
        @(posedge MAIN_CLK);
        #1;
        send(32'h40000000, 32'h40400000, 4'd5, 1'b1);
        drain();
        repeat (6) @(posedge MAIN_CLK);
        #1;

        // Randomized traffic with random back-pressure and bubbles
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(rnd_fp(), rnd_fp(), TAG_W'($urandom), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge MAIN_CLK);
                #1;
            end
        end
        rand_ready = 1'b0;
        ready_hold = 1'b1;
        drain();
        repeat (5) @(posedge MAIN_CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
